mdu_ctrl: RTL
=============

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: E-stage instruction is valid and issues op this cycle.
REQ-004 SHALL have port op, input, 4 bits: MDU operation code, values from package (REQ-024).
REQ-005 SHALL have port src_a, input, 32 bits: operand A (rs value).
REQ-006 SHALL have port src_b, input, 32 bits: operand B (rt value).
REQ-007 SHALL have port d_md_use, input, 1 bit: D-stage instruction is any MDU instruction.
REQ-008 SHALL have port busy, output, 1 bit: a multiply/divide is in flight.
REQ-009 SHALL have port stall, output, 1 bit: stall request to the hazard unit.
REQ-010 SHALL have port hi, output, 32 bits: architectural HI register.
REQ-011 SHALL have port lo, output, 32 bits: architectural LO register.
REQ-012 SHALL have port md_out, output, 32 bits: MFHI/MFLO read data.

Function
REQ-013 SHALL implement two states, IDLE and BUSY, plus down-counter cnt (4 bits).
- IDLE -> BUSY: start=1 and op in {MULT, MULTU, DIV, DIVU}.
- On entry: latch the full result into pending_hi/pending_lo; cnt <= MULT_LAT (5) or DIV_LAT (10).
REQ-014 SHALL, in BUSY, decrement cnt each edge.
- At the edge where cnt==1: hi <= pending_hi, lo <= pending_lo, return to IDLE.
- busy is high for exactly 5 (mult) or 10 (div) cycles, starting the cycle after acceptance.
- hi/lo update on the same edge that busy falls.
REQ-015 SHALL compute MULT as signed 32x32->64 and MULTU as unsigned: hi=[63:32], lo=[31:0].
REQ-016 SHALL compute DIV as signed: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend. DIVU SHALL be the unsigned equivalent.
REQ-017 SHALL handle signed overflow for DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
REQ-018 SHALL handle divide by zero (src_b=0) for DIV/DIVU: take the full 10-cycle latency, then leave hi and lo unchanged.
REQ-019 SHALL apply MTHI/MTLO when start=1 and busy=0: hi (resp. lo) <= src_a on the next edge, no busy cycles.
REQ-020 SHALL ignore start while busy=1 for every op; no state change results.
REQ-021 SHALL drive md_out combinationally: hi when op==MFHI, lo when op==MFLO, else 0.
REQ-022 SHALL drive stall = d_md_use & (busy | (start & op in {MULT, MULTU, DIV, DIVU})).

Reset
REQ-023 SHALL, on reset assertion and without waiting for a clock edge:
- clear state to IDLE;
- clear cnt, hi, lo, pending_hi and pending_lo to 0;
- drive busy=0.
This applies also mid-operation; the in-flight result SHALL be discarded.

Structure
REQ-024 SHALL take from shared package mdu_pkg:
- op codes NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8;
- constants MULT_LAT=5 and DIV_LAT=10;
- the state enum.
REQ-025 SHALL be a single module with no sub-module; arithmetic is inferred inline.

Verification
REQ-026 SHALL cover MULT with a=0xFFFFFFFD, b=5: busy high cycles 1-5, then hi=0xFFFFFFFF and lo=0xFFFFFFF1.
REQ-027 SHALL cover MULTU with the same operands: hi=0x00000004, lo=0xFFFFFFF1.
REQ-028 SHALL cover DIV with a=-7, b=2: busy 10 cycles, then lo=0xFFFFFFFD and hi=0xFFFFFFFF.
REQ-029 SHALL cover DIVU with a=7, b=2: lo=3, hi=1.
REQ-030 SHALL cover a second DIV issued while busy: it is ignored, and stall=1 throughout whenever d_md_use=1.
REQ-031 SHALL cover reset asserted at cycle 3 of a DIV: busy=0 and hi=lo=0 immediately; no update at the original completion cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit controller.
//   - MDU operation codes carried on the 4-bit op field
//   - result latencies for multiply and divide
//   - controller state encoding
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT  = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_md_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller owning the HI/LO registers.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | unit free; accepts MULT/MULTU/DIV/DIVU, applies MTHI/MTLO
//   ST_BUSY | result held in pending_*; cnt counts down to the HI/LO write
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   start     in   E-stage instruction issues op this cycle
//   op        in   [3:0] operation code (mdu_pkg OP_*)
//   src_a     in   [31:0] operand A (rs)
//   src_b     in   [31:0] operand B (rt)
//   d_md_use  in   D-stage instruction is an MDU instruction
//   busy      out  multiply/divide in flight
//   stall     out  stall request to the hazard unit
//   hi, lo    out  [31:0] architectural HI/LO
//   md_out    out  [31:0] MFHI/MFLO read data
module mdu_ctrl
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] pending_hi;
  logic [31:0] pending_lo;
  logic        pending_wr;

  logic [63:0]        mul_s;
  logic [63:0]        mul_u;
  logic               div_ovf;
  logic [31:0]        div_b;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               res_wr;
  logic [3:0]         res_lat;

  always_comb begin
    mul_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    mul_u = {32'd0, src_a} * {32'd0, src_b};

    // The divider never sees a zero divisor or the INT_MIN/-1 pair; both
    // cases are resolved explicitly below.
    div_ovf = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    div_b   = ((src_b == 32'd0) || div_ovf) ? 32'd1 : src_b;
    sa      = src_a;
    sb      = div_b;
    quo_s   = sa / sb;
    rem_s   = sa % sb;
    if (div_ovf) begin
      quo_s = 32'sh8000_0000;
      rem_s = 32'sd0;
    end
    quo_u = src_a / div_b;
    rem_u = src_a % div_b;

    res_hi  = 32'd0;
    res_lo  = 32'd0;
    res_wr  = 1'b1;
    res_lat = DIV_LAT;
    unique case (op)
      OP_MULT: begin
        res_hi  = mul_s[63:32];
        res_lo  = mul_s[31:0];
        res_lat = MULT_LAT;
      end
      OP_MULTU: begin
        res_hi  = mul_u[63:32];
        res_lo  = mul_u[31:0];
        res_lat = MULT_LAT;
      end
      OP_DIV: begin
        res_hi = rem_s;
        res_lo = quo_s;
        res_wr = (src_b != 32'd0);
      end
      OP_DIVU: begin
        res_hi = rem_u;
        res_lo = quo_u;
        res_wr = (src_b != 32'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
      pending_wr <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_md_op(op)) begin
              state      <= ST_BUSY;
              cnt        <= res_lat;
              pending_hi <= res_hi;
              pending_lo <= res_lo;
              pending_wr <= res_wr;
            end else if (op == OP_MTHI) begin
              hi <= src_a;
            end else if (op == OP_MTLO) begin
              lo <= src_a;
            end
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ST_IDLE;
            // Divide by zero still burns the full latency but commits nothing.
            if (pending_wr) begin
              hi <= pending_hi;
              lo <= pending_lo;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (state == ST_BUSY);
  assign stall  = d_md_use & (busy | (start & is_md_op(op)));
  assign md_out = (op == OP_MFHI) ? hi : ((op == OP_MFLO) ? lo : 32'd0);

endmodule
